// File: rtl/matrix_memory_if.sv
// Window-read and tile-merge port between the current-tile logic (master)
// and the playfield store (slave).
interface matrix_memory_if #(
    parameter int unsigned coord_w_p = 6
);
    typedef struct packed {
        logic signed [coord_w_p-1:0] x_m;
        logic signed [coord_w_p-1:0] y_m;
    } point_t;

    typedef logic [3:0][3:0] shape_t;

    point_t          mm_addr_i;
    logic [3:0][3:0] mm_data_o;
    logic            merge_v_i;
    point_t          merge_pos_i;
    shape_t          merge_shape_i;
    logic            ready_o;
    logic            done_o;
    logic [2:0]      lines_cleared_o;
    logic            game_over_o;

    modport slave (
        input  mm_addr_i, merge_v_i, merge_pos_i, merge_shape_i,
        output mm_data_o, ready_o, done_o, lines_cleared_o, game_over_o
    );

    modport master (
        output mm_addr_i, merge_v_i, merge_pos_i, merge_shape_i,
        input  mm_data_o, ready_o, done_o, lines_cleared_o, game_over_o
    );
endinterface

// File: rtl/matrix_memory.sv
// Tetris playfield store: combinational 4x4 window read, tile merge, display row port.
// Define TETRIS_LINE_CLEAR_EN to build the row-scan/shift FSM that removes full lines.
module matrix_memory #(
    parameter int unsigned width_p  = 10,
    parameter int unsigned height_p = 20
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    matrix_memory_if.slave     mm,
    input  logic [4:0]         disp_y_i,
    output logic [width_p-1:0] disp_row_o
);
    localparam int unsigned row_w_lp = $clog2(height_p);
    localparam int unsigned col_w_lp = $clog2(width_p);

    typedef enum logic [1:0] {eIDLE, eScan, eShift, eDone} state_e;

    state_e                           state_q, state_d;
    logic [height_p-1:0][width_p-1:0] board_q, board_d;
    logic                             ready_q, ready_d;
    logic                             done_q, done_d;
    logic                             game_over_q, game_over_d;
`ifdef TETRIS_LINE_CLEAR_EN
    logic [row_w_lp-1:0]              ptr_q, ptr_d;
    logic [2:0]                       count_q, count_d;
    logic [2:0]                       lines_q, lines_d;
    logic [height_p-1:0][width_p-1:0] shifted;

    // Packed shift moves every row one step towards the floor; row 0 fills with 0.
    assign shifted = board_q << width_p;
`endif

    always_comb begin
        mm.mm_data_o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                int x;
                int y;
                x = int'(mm.mm_addr_i.x_m) + int'(c);
                y = int'(mm.mm_addr_i.y_m) + int'(r);
                if (x < 0 || x >= int'(width_p) || y >= int'(height_p))
                    mm.mm_data_o[2'(r)][2'(c)] = 1'b1;
                else if (y >= 0)
                    mm.mm_data_o[2'(r)][2'(c)] = board_q[row_w_lp'(y)][col_w_lp'(x)];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        game_over_d = game_over_q;
`ifdef TETRIS_LINE_CLEAR_EN
        ptr_d       = ptr_q;
        count_d     = count_q;
        lines_d     = lines_q;
`endif
        if (clear_i) begin
            state_d     = eIDLE;
            board_d     = '0;
            game_over_d = 1'b0;
`ifdef TETRIS_LINE_CLEAR_EN
            lines_d     = '0;
`endif
        end else begin
            case (state_q)
                eIDLE: begin
                    if (mm.merge_v_i) begin
                        for (int unsigned r = 0; r < 4; r++) begin
                            for (int unsigned c = 0; c < 4; c++) begin
                                int x;
                                int y;
                                x = int'(mm.merge_pos_i.x_m) + int'(c);
                                y = int'(mm.merge_pos_i.y_m) + int'(r);
                                if (mm.merge_shape_i[2'(r)][2'(c)]) begin
                                    if (y < 0)
                                        game_over_d = 1'b1;
                                    else if (x >= 0 && x < int'(width_p) && y < int'(height_p))
                                        board_d[row_w_lp'(y)][col_w_lp'(x)] = 1'b1;
                                end
                            end
                        end
`ifdef TETRIS_LINE_CLEAR_EN
                        ptr_d   = row_w_lp'(height_p - 1);
                        count_d = '0;
                        state_d = eScan;
`else
                        state_d = eDone;
`endif
                    end
                end
`ifdef TETRIS_LINE_CLEAR_EN
                eScan: begin
                    if (&board_q[ptr_q])
                        state_d = eShift;
                    else if (ptr_q == '0)
                        state_d = eDone;
                    else
                        ptr_d = ptr_q - 1'b1;
                end
                eShift: begin
                    for (int unsigned i = 0; i < height_p; i++) begin
                        if (i <= 32'(ptr_q))
                            board_d[row_w_lp'(i)] = shifted[row_w_lp'(i)];
                    end
                    count_d = count_q + 3'd1;
                    state_d = eScan;
                end
`endif
                eDone:   state_d = eIDLE;
                default: state_d = eIDLE;
            endcase
        end
        // Outputs are registered from the next state so they line up with the state they describe.
        ready_d = (state_d == eIDLE);
        done_d  = (state_d == eDone);
`ifdef TETRIS_LINE_CLEAR_EN
        if (state_d == eDone)
            lines_d = count_d;
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= eIDLE;
            board_q     <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            game_over_q <= 1'b0;
`ifdef TETRIS_LINE_CLEAR_EN
            ptr_q       <= '0;
            count_q     <= '0;
            lines_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            game_over_q <= game_over_d;
`ifdef TETRIS_LINE_CLEAR_EN
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            lines_q     <= lines_d;
`endif
        end
    end

    assign mm.ready_o     = ready_q;
    assign mm.done_o      = done_q;
    assign mm.game_over_o = game_over_q;
`ifdef TETRIS_LINE_CLEAR_EN
    assign mm.lines_cleared_o = lines_q;
`else
    assign mm.lines_cleared_o = '0;
`endif

    always_comb begin
        disp_row_o = '0;
        if (int'(disp_y_i) < int'(height_p))
            disp_row_o = board_q[row_w_lp'(disp_y_i)];
    end
endmodule
